// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per request: maps opcode, drives ALU ports, captures result/ZERO.
// Latency 2 cycles (legal) / 1 cycle (illegal); response held until rsp_ready, req_ready low meanwhile.
module alu_op_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_control,
    input  logic [31:0]        alu_out,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               rsp_zero,
    output logic               rsp_neg,
    output logic               rsp_err,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [3:0]         alu_control_q, alu_control_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_neg_q, rsp_neg_d;
    logic               rsp_err_q, rsp_err_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic [3:0] mapped_ctl;

    always_comb begin
        mapped_ctl = 4'b0000;
        case (req_op)
            3'b000:  mapped_ctl = 4'b0000;
            3'b001:  mapped_ctl = 4'b0001;
            3'b010:  mapped_ctl = 4'b0010;
            3'b011:  mapped_ctl = 4'b0110;
            3'b100:  mapped_ctl = 4'b0111;
            3'b101:  mapped_ctl = 4'b1100;
            3'b110:  mapped_ctl = 4'b0110;
            default: mapped_ctl = 4'b0000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        op_d          = op_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_neg_d     = rsp_neg_q;
        rsp_err_d     = rsp_err_q;
        op_count_d    = op_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    req_ready_d = 1'b0;
                    // Illegal ops never touch the ALU ports, so the ALU stays on a defined code.
                    if (req_op == OP_ILLEGAL) begin
                        rsp_data_d  = 32'h0;
                        rsp_zero_d  = 1'b0;
                        rsp_neg_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_a_d       = req_a;
                        alu_b_d       = req_b;
                        alu_control_d = mapped_ctl;
                        state_d       = EXEC;
                    end
                end
            end
            EXEC: begin
                rsp_data_d  = (op_q == OP_CMP) ? 32'h0 : alu_out;
                rsp_zero_d  = alu_zero;
                rsp_neg_d   = alu_out[31];
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    op_count_d  = op_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            alu_a_q       <= 32'h0;
            alu_b_q       <= 32'h0;
            alu_control_q <= 4'b0000;
            op_q          <= 3'b000;
            rsp_data_q    <= 32'h0;
            rsp_zero_q    <= 1'b0;
            rsp_neg_q     <= 1'b0;
            rsp_err_q     <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            op_q          <= op_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_neg_q     <= rsp_neg_d;
            rsp_err_q     <= rsp_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_neg     = rsp_neg_q;
    assign rsp_err     = rsp_err_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed requests into a scoreboard, monitor checks every response.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_neg;
    logic        rsp_err;
    logic [1:0]  op_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        neg;
        logic        err;
        logic [3:0]  ctl;
        logic [1:0]  cnt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the datapath ALU.
    always_comb begin
        case (alu_control)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = alu_b;
            4'b1100: alu_out = ~(alu_a | alu_b);
            default: alu_out = 'x;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    alu_op_sequencer #(.COUNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_neg     (rsp_neg),
        .rsp_err     (rsp_err),
        .op_count    (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] data, input logic z, input logic n, input logic er,
                        input logic [3:0] ctl, input logic [1:0] cnt, input int bp);
        exp_t e;
        bit   rdy;
        int   budget;
        @(posedge clk);
        #1;
        if (bp > 0) rsp_ready = 1'b0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rdy       = 1'b0;
        budget    = 50;
        while (!rdy && budget > 0) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            budget--;
        end
        #1;
        req_valid = 1'b0;
        if (!rdy) begin
            fail_now("accept");
            return;
        end
        e.data = data; e.zero = z; e.neg = n; e.err = er;
        e.ctl  = ctl;  e.cnt  = cnt;
        e.lat  = er ? 0 : 1;
        e.acc  = cyc;
        sb_q.push_back(e);
        if (bp > 0) begin
            budget = 10;
            do @(negedge clk); while (!rsp_valid && --budget > 0);
            // A competing request while the response is stalled must be ignored.
            req_op    = 3'b010;
            req_a     = 32'h1111_1111;
            req_b     = 32'h2222_2222;
            req_valid = 1'b1;
            repeat (bp) @(posedge clk);
            #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        budget = 20;
        do @(negedge clk); while (!req_ready && --budget > 0);
        if (!req_ready) fail_now("return_idle");
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        bit         seen;
        bit         post;
        logic [1:0] pc;
        exp_t       e;
        seen = 1'b0;
        post = 1'b0;
        pc   = 2'd0;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("op_count_after_hs", 32'(op_count), 32'(pc));
                post = 1'b0;
            end
            if (rst_n && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%h expected=none", rsp_data);
                end else begin
                    e = sb_q[0];
                    if (!seen) begin
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                        seen = 1'b1;
                    end
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    chk("rsp_neg", 32'(rsp_neg), 32'(e.neg));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("alu_control", 32'(alu_control), 32'(e.ctl));
                    chk("req_ready_busy", 32'(req_ready), 32'(0));
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        seen = 1'b0;
                        post = 1'b1;
                        pc   = e.cnt;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'b010;
        req_a     = 32'h1;
        req_b     = 32'h2;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_control", 32'(alu_control), 32'(0));
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'(0));
        chk("rst_rsp_neg", 32'(rsp_neg), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(req_ready), 32'(1));

        //   op      a             b             data          z     n     err   ctl      cnt   bp
        send(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1, 0);
        send(3'b011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0110, 2'd2, 0);
        send(3'b110, 32'h00000003, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0110, 2'd3, 0);
        send(3'b100, 32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4'b0111, 2'd0, 0);
        send(3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 4'b1100, 2'd1, 5);
        send(3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 4'b1100, 2'd2, 0);
        chk("illegal_keeps_alu_a", alu_a, 32'h0);
        send(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 0);
        send(3'b001, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 0);

        // Reset while the accepted op is in EXEC: dropped, no response, no count.
        @(posedge clk);
        #1;
        req_op    = 3'b010;
        req_a     = 32'h1;
        req_b     = 32'h1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("midrst_in_exec", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'(0));
            chk("midrst_count", 32'(op_count), 32'(0));
        end

        send(3'b010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 0);
        send(3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd2, 0);
        send(3'b000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd3, 0);
        send(3'b011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 4'b0110, 2'd0, 0);
        send(3'b111, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 4'b0110, 2'd1, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
